screensaver_cfg_ctrl: RTL and testbench

Configuration controller for the bouncing-box image generator. Accepts register writes from a host or debug port through a valid/ready handshake into shadow registers. On a commit request it waits for the next frame boundary, then copies the shadow set to the active set in one cycle. The image block therefore never sees a configuration change mid-frame. It sits between the host port and the image block, and observes the video timer's frame counter.

---
 rtl/screensaver_cfg_if.sv | 39 +++
 rtl/screensaver_cfg_ctrl.sv | 88 ++++++++
 tb/tb_screensaver_cfg_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/screensaver_cfg_if.sv
// screensaver_cfg_if: host write/commit handshake, frame counter and active config bundle.
// Optional readback port under SCREENSAVER_CFG_READBACK_EN.
interface screensaver_cfg_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        commit_valid;
    logic        commit_ready;
    logic [31:0] frame;
    logic        busy;
    logic        cfg_update;
    logic [3:0]  speed_x;
    logic [3:0]  speed_y;
    logic [7:0]  box_size;
    logic [2:0]  color;
`ifdef SCREENSAVER_CFG_READBACK_EN
    logic [1:0]  rd_addr;
    logic [7:0]  rd_data;
`endif

    modport slave (
        input  wr_valid, wr_addr, wr_data, commit_valid, frame,
`ifdef SCREENSAVER_CFG_READBACK_EN
        input  rd_addr,
        output rd_data,
`endif
        output wr_ready, commit_ready, busy, cfg_update, speed_x, speed_y, box_size, color
    );

    modport master (
        output wr_valid, wr_addr, wr_data, commit_valid, frame,
`ifdef SCREENSAVER_CFG_READBACK_EN
        output rd_addr,
        input  rd_data,
`endif
        input  wr_ready, commit_ready, busy, cfg_update, speed_x, speed_y, box_size, color
    );
endinterface

// File: rtl/screensaver_cfg_ctrl.sv
// screensaver_cfg_ctrl: clamped shadow config registers applied to the active set at a frame boundary.
// Optional shadow readback under SCREENSAVER_CFG_READBACK_EN.
module screensaver_cfg_ctrl #(
    parameter int SPEED_MAX = 7,
    parameter int SIZE_MIN  = 16,
    parameter int SIZE_MAX  = 200
) (
    input logic clk,
    input logic rst,
    screensaver_cfg_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, APPLY} state_t;

    state_t      state, state_n;
    logic        idle_n;
    logic [31:0] frame_prev;
    logic        frame_edge;
    logic        wr_fire;
    logic [3:0]  sh_sx, sh_sy;
    logic [7:0]  sh_bs;
    logic [2:0]  sh_col;

    function automatic logic [3:0] clamp_speed(input logic [3:0] d);
        return d == 4'd0 ? 4'd1 : (d > SPEED_MAX[3:0]) ? SPEED_MAX[3:0] : d;
    endfunction

    function automatic logic [7:0] clamp_size(input logic [7:0] d);
        return d < SIZE_MIN[7:0] ? SIZE_MIN[7:0] : (d > SIZE_MAX[7:0]) ? SIZE_MAX[7:0] : d;
    endfunction

    assign frame_edge = (bus.frame != frame_prev) && !rst;
    assign wr_fire    = bus.wr_valid && bus.wr_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Edges seen while still IDLE (including the commit cycle) never advance ARMED.
    always_comb begin
        state_n = state;
        state_n = state == IDLE  ? (bus.commit_valid ? ARMED : IDLE) :
                  state == ARMED ? (frame_edge ? APPLY : ARMED) : IDLE;
        idle_n  = state_n == IDLE;
    end

    always_ff @(posedge clk) begin
        frame_prev <= bus.frame;
        if (rst) begin
            bus.wr_ready     <= 1'b1;
            bus.commit_ready <= 1'b1;
            bus.busy         <= 1'b0;
            bus.cfg_update   <= 1'b0;
            sh_sx            <= 4'd2;
            sh_sy            <= 4'd1;
            sh_bs            <= 8'd100;
            sh_col           <= 3'b111;
            bus.speed_x      <= 4'd2;
            bus.speed_y      <= 4'd1;
            bus.box_size     <= 8'd100;
            bus.color        <= 3'b111;
        end else begin
            bus.wr_ready     <= idle_n;
            bus.commit_ready <= idle_n;
            bus.busy         <= !idle_n;
            bus.cfg_update   <= state == APPLY;
            if (wr_fire && bus.wr_addr == 2'd0) sh_sx  <= clamp_speed(bus.wr_data[3:0]);
            if (wr_fire && bus.wr_addr == 2'd1) sh_sy  <= clamp_speed(bus.wr_data[3:0]);
            if (wr_fire && bus.wr_addr == 2'd2) sh_bs  <= clamp_size(bus.wr_data);
            if (wr_fire && bus.wr_addr == 2'd3) sh_col <= bus.wr_data[2:0] == 3'd0 ? 3'b001 : bus.wr_data[2:0];
            if (state == APPLY) begin
                bus.speed_x  <= sh_sx;
                bus.speed_y  <= sh_sy;
                bus.box_size <= sh_bs;
                bus.color    <= sh_col;
            end
        end
    end

`ifdef SCREENSAVER_CFG_READBACK_EN
    always_ff @(posedge clk) begin
        if (rst) bus.rd_data <= 8'd0;
        else     bus.rd_data <= bus.rd_addr == 2'd0 ? {4'd0, sh_sx} :
                                bus.rd_addr == 2'd1 ? {4'd0, sh_sy} :
                                bus.rd_addr == 2'd2 ? sh_bs : {5'd0, sh_col};
    end
`endif
endmodule

// File: tb/tb_screensaver_cfg_ctrl.sv
// tb_screensaver_cfg_ctrl: table-driven clamp/commit vectors plus directed multi-cycle sequences.
module tb_screensaver_cfg_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    screensaver_cfg_if bus();
    screensaver_cfg_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
        logic [3:0] sx;
        logic [3:0] sy;
        logic [7:0] bs;
        logic [2:0] col;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write(input logic [1:0] a, input logic [7:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic commit();
        bus.commit_valid = 1'b1;
        step();
        bus.commit_valid = 1'b0;
    endtask

    task automatic chk_active(input string name, input logic [3:0] sx, input logic [3:0] sy,
                              input logic [7:0] bs, input logic [2:0] col);
        chk({name, ".speed_x"}, 32'(bus.speed_x), 32'(sx));
        chk({name, ".speed_y"}, 32'(bus.speed_y), 32'(sy));
        chk({name, ".box_size"}, 32'(bus.box_size), 32'(bs));
        chk({name, ".color"}, 32'(bus.color), 32'(col));
    endtask

    initial begin
        vecs[0]  = '{2'd0, 8'd0,   4'd1, 4'd1, 8'd150, 3'd7};
        vecs[1]  = '{2'd1, 8'd12,  4'd1, 4'd7, 8'd150, 3'd7};
        vecs[2]  = '{2'd2, 8'd3,   4'd1, 4'd7, 8'd16,  3'd7};
        vecs[3]  = '{2'd2, 8'd255, 4'd1, 4'd7, 8'd200, 3'd7};
        vecs[4]  = '{2'd3, 8'd0,   4'd1, 4'd7, 8'd200, 3'd1};
        vecs[5]  = '{2'd0, 8'd7,   4'd7, 4'd7, 8'd200, 3'd1};
        vecs[6]  = '{2'd0, 8'd8,   4'd7, 4'd7, 8'd200, 3'd1};
        vecs[7]  = '{2'd0, 8'h13,  4'd3, 4'd7, 8'd200, 3'd1};
        vecs[8]  = '{2'd2, 8'd15,  4'd3, 4'd7, 8'd16,  3'd1};
        vecs[9]  = '{2'd2, 8'd16,  4'd3, 4'd7, 8'd16,  3'd1};
        vecs[10] = '{2'd2, 8'd201, 4'd3, 4'd7, 8'd200, 3'd1};
        vecs[11] = '{2'd3, 8'h0D,  4'd3, 4'd7, 8'd200, 3'd5};
        vecs[12] = '{2'd1, 8'd1,   4'd3, 4'd1, 8'd200, 3'd5};

        bus.wr_valid = 1'b0;
        bus.wr_addr = 2'd0;
        bus.wr_data = 8'd0;
        bus.commit_valid = 1'b0;
        bus.frame = 32'd10;
`ifdef SCREENSAVER_CFG_READBACK_EN
        bus.rd_addr = 2'd0;
`endif
        step();
        step();
        rst = 1'b0;
        step();
        chk_active("reset", 4'd2, 4'd1, 8'd100, 3'd7);
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("reset.commit_ready", 32'(bus.commit_ready), 32'd1);
        chk("reset.cfg_update", 32'(bus.cfg_update), 32'd0);

        write(2'd0, 8'd5);
        write(2'd2, 8'd150);
        commit();
        chk("armed.busy", 32'(bus.busy), 32'd1);
        chk("armed.wr_ready", 32'(bus.wr_ready), 32'd0);
        step();
        step();
        chk_active("pre_edge", 4'd2, 4'd1, 8'd100, 3'd7);
        bus.frame = 32'd11;
        step();
        chk("edge+1.cfg_update", 32'(bus.cfg_update), 32'd0);
        chk("edge+1.speed_x", 32'(bus.speed_x), 32'd2);
        step();
        chk("edge+2.cfg_update", 32'(bus.cfg_update), 32'd1);
        chk("edge+2.busy", 32'(bus.busy), 32'd0);
        chk_active("edge+2", 4'd5, 4'd1, 8'd150, 3'd7);
        step();
        chk("edge+3.cfg_update", 32'(bus.cfg_update), 32'd0);

        for (int i = 0; i < 13; i++) begin
            write(vecs[i].addr, vecs[i].data);
            commit();
            bus.frame = bus.frame + 32'd1;
            step();
            step();
            chk($sformatf("vec%0d.cfg_update", i), 32'(bus.cfg_update), 32'd1);
            chk_active($sformatf("vec%0d", i), vecs[i].sx, vecs[i].sy, vecs[i].bs, vecs[i].col);
        end
        step();

        bus.frame = 32'd20;
        step();
        bus.commit_valid = 1'b1;
        bus.frame = 32'd21;
        step();
        bus.commit_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("cedge%0d.busy", i), 32'(bus.busy), 32'd1);
            chk($sformatf("cedge%0d.cfg_update", i), 32'(bus.cfg_update), 32'd0);
            step();
        end
        bus.frame = 32'd22;
        step();
        step();
        chk("cedge.apply", 32'(bus.cfg_update), 32'd1);
        chk_active("cedge", 4'd3, 4'd1, 8'd200, 3'd5);
        step();

        bus.frame = 32'hFFFF_FFFF;
        step();
        commit();
        bus.wr_valid = 1'b1;
        bus.wr_addr = 2'd0;
        bus.wr_data = 8'd6;
        step();
        chk("bp.wr_ready", 32'(bus.wr_ready), 32'd0);
        bus.frame = 32'd0;
        step();
        step();
        chk("wrap.cfg_update", 32'(bus.cfg_update), 32'd1);
        chk("bp.shadow_kept", 32'(bus.speed_x), 32'd3);
        chk("bp.wr_ready_idle", 32'(bus.wr_ready), 32'd1);
        step();
        bus.wr_valid = 1'b0;
        commit();
        bus.frame = 32'd1;
        step();
        step();
        chk("bp.accepted", 32'(bus.speed_x), 32'd6);
        step();

        write(2'd0, 8'd4);
        commit();
        rst = 1'b1;
        step();
        chk("rst_armed.cfg_update0", 32'(bus.cfg_update), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("rst_armed.busy", 32'(bus.busy), 32'd0);
        chk("rst_armed.wr_ready", 32'(bus.wr_ready), 32'd1);
        chk_active("rst_armed", 4'd2, 4'd1, 8'd100, 3'd7);
        bus.frame = 32'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst_noupd%0d", i), 32'(bus.cfg_update), 32'd0);
        end
        chk("rst_noupd.speed_x", 32'(bus.speed_x), 32'd2);
        commit();
        bus.frame = 32'd3;
        step();
        step();
        chk("rst_shadow.cfg_update", 32'(bus.cfg_update), 32'd1);
        chk("rst_shadow.speed_x", 32'(bus.speed_x), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
